// File: rtl/text_scan_ctrl.sv
// text_scan_ctrl: scan sequencer for an 80x25 text framebuffer.
// Generates 720x400@70Hz VGA timing, drives the framebuffer character
// address, forms the font ROM address and serialises glyph slices into a
// pixel stream with mutually aligned de/hsync/vsync/frame_start.
// Also snapshots the four live note IDs once per frame at the start of
// vertical blank.
// Optional feature macro: TEXT_SCAN_CURSOR_EN (blinking underline-style
// block cursor on glyph rows 14/15 of the cell addressed by cur_pos).

module text_scan_ctrl #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 18,
    parameter int H_SYNC   = 108,
    parameter int H_BP     = 54,
    parameter int V_ACTIVE = 400,
    parameter int V_FP     = 12,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 35,
    parameter int COLS     = 80,
    parameter int FONT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  key_in0,
    input  logic [6:0]  key_in1,
    input  logic [6:0]  key_in2,
    input  logic [6:0]  key_in3,
    output logic [6:0]  key0,
    output logic [6:0]  key1,
    output logic [6:0]  key2,
    output logic [6:0]  key3,
    output logic [10:0] pos,
    input  logic [7:0]  char,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_bits,
`ifdef TEXT_SCAN_CURSOR_EN
    input  logic [10:0] cur_pos,
`endif
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    // Output alignment depth: pos, char, font_addr, font_bits (FONT_LAT), pixel
    localparam int L       = 4 + FONT_LAT;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0]    POS_IDLE = 11'h7FF;

    // Raster and cell-tracking state
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [3:0]     x_sub;
    logic [6:0]     col;
    logic [3:0]     y_sub;
    logic [10:0]    row_base;

    // Stage-0 decode
    logic           h_act;
    logic           v_act;
    logic           active;
    logic           h_last;
    logic           v_last;
    logic [10:0]    cell_addr;
    logic           de_raw;
    logic           hs_raw;
    logic           vs_raw;
    logic           fs_raw;
    logic           snap;

    // Pipelines
    logic [3:0]     y_d1;
    logic [3:0]     y_d2;
    logic [L-1:0]   de_pipe;
    logic [L-1:0]   hs_pipe;
    logic [L-1:0]   vs_pipe;
    logic [L-1:0]   fs_pipe;
    logic [3:0]     x_pipe [L-1];

    // Pixel stage
    logic [3:0]     x_cur;
    logic           glyph_bit;
    logic           cursor_inv;

`ifdef TEXT_SCAN_CURSOR_EN
    logic           cur_hit;
    logic [L-3:0]   cur_pipe;
    logic [5:0]     frame_cnt;
`endif

    // Stage-0 decode of the raster position
    always_comb begin
        h_act     = h_cnt < H_ACT_C;
        v_act     = v_cnt < V_ACT_C;
        active    = h_act && v_act;
        h_last    = h_cnt == H_LAST;
        v_last    = v_cnt == V_LAST;
        cell_addr = row_base + 11'(col);
        de_raw    = active;
        hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);
        fs_raw    = (h_cnt == '0) && (v_cnt == '0);
        snap      = (h_cnt == '0) && (v_cnt == V_ACT_C);
    end

    // Raster counters plus incremental cell tracking (no multiply/divide)
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            x_sub    <= '0;
            col      <= '0;
            y_sub    <= '0;
            row_base <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            x_sub <= '0;
            col   <= '0;
            if (v_last) begin
                v_cnt    <= '0;
                y_sub    <= '0;
                row_base <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
                if (v_act) begin
                    if (y_sub == 4'd15) begin
                        y_sub    <= '0;
                        row_base <= row_base + 11'(COLS);
                    end else begin
                        y_sub <= y_sub + 4'd1;
                    end
                end
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (h_act) begin
                if (x_sub == 4'd8) begin
                    x_sub <= '0;
                    col   <= col + 7'd1;
                end else begin
                    x_sub <= x_sub + 4'd1;
                end
            end
        end
    end

    // Stage 1: framebuffer address, parked on the blank cell outside active video
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= POS_IDLE;
        end else begin
            pos <= active ? cell_addr : POS_IDLE;
        end
    end

    // Stage 3: font ROM address from returned character and glyph row
    always_ff @(posedge clk) begin
        if (rst) begin
            y_d1      <= '0;
            y_d2      <= '0;
            font_addr <= '0;
        end else begin
            y_d1      <= y_sub;
            y_d2      <= y_d1;
            font_addr <= {char, y_d2};
        end
    end

    // Timing-signal and sub-pixel delay lines matching the data path depth
    always_ff @(posedge clk) begin
        if (rst) begin
            de_pipe <= '0;
            hs_pipe <= '1;
            vs_pipe <= '0;
            fs_pipe <= '0;
            for (int unsigned i = 0; i < L - 1; i++) begin
                x_pipe[i] <= '0;
            end
        end else begin
            de_pipe   <= {de_pipe[L-2:0], de_raw};
            hs_pipe   <= {hs_pipe[L-2:0], hs_raw};
            vs_pipe   <= {vs_pipe[L-2:0], vs_raw};
            fs_pipe   <= {fs_pipe[L-2:0], fs_raw};
            x_pipe[0] <= x_sub;
            for (int unsigned i = 1; i < L - 1; i++) begin
                x_pipe[i] <= x_pipe[i-1];
            end
        end
    end

`ifdef TEXT_SCAN_CURSOR_EN
    // Cursor cell match, formed alongside pos and carried to the pixel stage
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_hit  <= 1'b0;
            cur_pipe <= '0;
        end else begin
            cur_hit  <= active && (cell_addr == cur_pos) && (y_sub[3:1] == 3'b111);
            cur_pipe <= {cur_pipe[L-4:0], cur_hit};
        end
    end

    // Blink timebase: counts emitted frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end
`endif

    // Glyph bit selection, gap column and optional cursor inversion
    always_comb begin
        x_cur      = x_pipe[L-2];
        glyph_bit  = 1'b0;
        cursor_inv = 1'b0;
        if (x_cur < 4'd8) begin
            glyph_bit = font_bits[3'd7 - x_cur[2:0]];
        end
`ifdef TEXT_SCAN_CURSOR_EN
        cursor_inv = cur_pipe[L-3] & frame_cnt[5];
`endif
    end

    // Final pixel register, blanked outside the display window
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel <= 1'b0;
        end else begin
            pixel <= de_pipe[L-2] & (glyph_bit ^ cursor_inv);
        end
    end

    // Per-frame note snapshot on the first blank line
    always_ff @(posedge clk) begin
        if (rst) begin
            key0 <= '0;
            key1 <= '0;
            key2 <= '0;
            key3 <= '0;
        end else if (snap) begin
            key0 <= key_in0;
            key1 <= key_in1;
            key2 <= key_in2;
            key3 <= key_in3;
        end
    end

    assign de          = de_pipe[L-1];
    assign hsync       = hs_pipe[L-1];
    assign vsync       = vs_pipe[L-1];
    assign frame_start = fs_pipe[L-1];

endmodule

// File: tb/tb_text_scan_ctrl.sv
// Scoreboard bench for text_scan_ctrl: one instance with the 720x400
// geometry (FONT_LAT=1) and one reduced-geometry instance (FONT_LAT=2)
// so whole frames, vblank and key snapshots fit in a short run.
// Expected outputs come from raster arithmetic on (h,v) plus bench-side
// framebuffer/font memories.

module tb_text_scan_ctrl;

    typedef struct {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int cols; int lat;
    } geom_t;

    typedef struct {
        int          cyc;
        int          inst;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] key_in0 = '0, key_in1 = '0, key_in2 = '0, key_in3 = '0;

    logic [6:0]  ka0, ka1, ka2, ka3, kb0, kb1, kb2, kb3;
    logic [10:0] pos_a, pos_b;
    logic [7:0]  char_a, char_b, fbits_a, fbits_b, rb1;
    logic [11:0] fa_a, fa_b;
    logic        pix_a, de_a, hs_a, vs_a, fs_a;
    logic        pix_b, de_b, hs_b, vs_b, fs_b;

    logic [7:0] fb_mem [0:1999];
    logic [7:0] rom    [0:4095];

    geom_t geo [2];
    int    hh [2];
    int    vv [2];
    logic [27:0] ekey [2];

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_scan_ctrl dut_a (
        .clk(clk), .rst(rst),
        .key_in0(key_in0), .key_in1(key_in1), .key_in2(key_in2), .key_in3(key_in3),
        .key0(ka0), .key1(ka1), .key2(ka2), .key3(ka3),
        .pos(pos_a), .char(char_a), .font_addr(fa_a), .font_bits(fbits_a),
        .pixel(pix_a), .de(de_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    text_scan_ctrl #(
        .H_ACTIVE(36), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .COLS(4), .FONT_LAT(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .key_in0(key_in0), .key_in1(key_in1), .key_in2(key_in2), .key_in3(key_in3),
        .key0(kb0), .key1(kb1), .key2(kb2), .key3(kb3),
        .pos(pos_b), .char(char_b), .font_addr(fa_b), .font_bits(fbits_b),
        .pixel(pix_b), .de(de_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    function automatic logic [7:0] fb_read(input logic [10:0] p);
        return (p < 11'd2000) ? fb_mem[p] : 8'h20;
    endfunction

    // Framebuffer (1 clk) and font ROMs (1 and 2 clk) environment models
    always @(posedge clk) begin
        char_a  <= fb_read(pos_a);
        char_b  <= fb_read(pos_b);
        fbits_a <= rom[fa_a];
        rb1     <= rom[fa_b];
        fbits_b <= rb1;
    end

    function automatic logic [63:0] observe(input int inst, input int kind);
        logic [63:0] r;
        r = '0;
        if (inst == 0) begin
            case (kind)
                0: r = {25'b0, pos_a, ka3, ka2, ka1, ka0};
                1: r = {52'b0, fa_a};
                default: r = {59'b0, pix_a, de_a, hs_a, vs_a, fs_a};
            endcase
        end else begin
            case (kind)
                0: r = {25'b0, pos_b, kb3, kb2, kb1, kb0};
                1: r = {52'b0, fa_b};
                default: r = {59'b0, pix_b, de_b, hs_b, vs_b, fs_b};
            endcase
        end
        return r;
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            0: return "pos_keys";
            1: return "font_addr";
            default: return "video{pix,de,hs,vs,fs}";
        endcase
    endfunction

    // Monitor: pops every expectation that targets the current cycle
    always @(negedge clk) begin
        logic [63:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                obs = observe(sb[i].inst, sb[i].kind);
                n_assert++;
                if (obs !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s inst%0d cyc %0d: got %h expected %h",
                             kind_name(sb[i].kind), sb[i].inst, cyc, obs, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_assert++;
                n_fail++;
                $display("FAIL stale_%s inst%0d: due cyc %0d, now %0d",
                         kind_name(sb[i].kind), sb[i].inst, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int when, input int inst, input int kind, input logic [63:0] v);
        exp_t e;
        e.cyc  = when;
        e.inst = inst;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    // One clock of stimulus plus the expected responses it implies
    task automatic step(input logic r);
        int h, v, x, htot, vtot;
        logic de_e, hs_e, vs_e, fs_e, px;
        logic [10:0] p;
        logic [11:0] fa;
        logic [7:0]  gl;
        rst = r;
        if (r) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc > cyc) sb.delete(i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                ekey[i] = '0;
                hh[i] = 0;
                vv[i] = 0;
                push(cyc + 1, i, 0, {25'b0, 11'h7FF, 28'b0});
                for (int j = 1; j <= 4 + geo[i].lat; j++)
                    push(cyc + j, i, 2, {59'b0, 5'b00100});
            end else begin
                h = hh[i];
                v = vv[i];
                de_e = (h < geo[i].ha) && (v < geo[i].va);
                hs_e = !((h >= geo[i].ha + geo[i].hfp) && (h < geo[i].ha + geo[i].hfp + geo[i].hs));
                vs_e = (v >= geo[i].va + geo[i].vfp) && (v < geo[i].va + geo[i].vfp + geo[i].vs);
                fs_e = (h == 0) && (v == 0);
                p    = de_e ? 11'((v / 16) * geo[i].cols + h / 9) : 11'h7FF;
                x    = h % 9;
                fa   = {fb_read(p), 4'(v % 16)};
                gl   = rom[fa];
                px   = de_e && (x < 8) && gl[7 - x];
                if (h == 0 && v == geo[i].va)
                    ekey[i] = {key_in3, key_in2, key_in1, key_in0};
                push(cyc + 1, i, 0, {25'b0, p, ekey[i]});
                if (de_e) push(cyc + 3, i, 1, {52'b0, fa});
                push(cyc + 4 + geo[i].lat, i, 2, {59'b0, px, de_e, hs_e, vs_e, fs_e});
                htot = geo[i].ha + geo[i].hfp + geo[i].hs + geo[i].hbp;
                vtot = geo[i].va + geo[i].vfp + geo[i].vs + geo[i].vbp;
                hh[i] = h + 1;
                if (hh[i] == htot) begin
                    hh[i] = 0;
                    vv[i] = (v + 1 == vtot) ? 0 : v + 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r);
        @(posedge clk);
        #1;
        if ($urandom_range(0, 299) == 0) key_in0 = 7'($urandom);
        if ($urandom_range(0, 299) == 0) key_in1 = 7'($urandom);
        if ($urandom_range(0, 299) == 0) key_in2 = 7'($urandom);
        if ($urandom_range(0, 299) == 0) key_in3 = 7'($urandom);
        // Change inputs on the snapshot clock itself now and then
        if (hh[1] == 0 && vv[1] == geo[1].va && $urandom_range(0, 1) == 1) begin
            key_in0 = 7'($urandom);
            key_in3 = 7'($urandom);
        end
        step(r);
    endtask

    initial begin
        int mid;
        geo[0] = '{ha:720, hfp:18, hs:108, hbp:54, va:400, vfp:12, vs:2, vbp:35, cols:80, lat:1};
        geo[1] = '{ha:36,  hfp:3,  hs:5,   hbp:4,  va:32,  vfp:2,  vs:2, vbp:3,  cols:4,  lat:2};
        for (int i = 0; i < 2000; i++) fb_mem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        fb_mem[0]    = 8'h41;
        rom[12'h410] = 8'hA5;
        hh[0] = 0; hh[1] = 0; vv[0] = 0; vv[1] = 0;
        ekey[0] = '0; ekey[1] = '0;

        repeat (4) cycle(1'b1);
        mid = 4 * 1872 + int'($urandom_range(300, 1500));
        repeat (mid) cycle(1'b0);
        cycle(1'b1);
        repeat (16 * 900 + 940) cycle(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/text_scan_ctrl.md
Name: text_scan_ctrl

Overview:
- Scan sequencer for the 80x25 text framebuffer.
- Generates 720x400@70 Hz VGA timing from the pixel clock and drives the framebuffer `pos` address.
- Feeds the returned character code, plus the glyph row, to the font ROM and serialises the 8-bit glyph slice into a pixel stream with aligned hsync/vsync/de.
- Also snapshots the four track note IDs once per frame (start of vblank) so the framebuffer never shows a torn value.

Parameters:
- H_ACTIVE, 720, visible pixels per line
- H_FP, 18, horizontal front porch
- H_SYNC, 108, hsync pulse width
- H_BP, 54, horizontal back porch
- V_ACTIVE, 400, visible lines
- V_FP, 12, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 35, vertical back porch
- COLS, 80, text columns; also the row stride of pos
- FONT_LAT, 1, font ROM read latency in clocks (1 or 2)

Ports:
- clk  in  1  pixel clock (28.322 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_in0..key_in3  in  7 each  live note IDs from the sequencer
- key0..key3  out  7 each  per-frame snapshots, wired to framebuffer key0..key3
- pos  out  11  framebuffer character address
- char  in  8  framebuffer read data; 1-clock registered latency after pos
- font_addr  out  12  {char, glyph_row[3:0]} to the font ROM
- font_bits  in  8  font ROM data; bit 7 = leftmost pixel; FONT_LAT clocks after font_addr
- pixel  out  1  foreground pixel
- de  out  1  display enable
- hsync  out  1  active-low
- vsync  out  1  active-high
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame

Behaviour:
- Counters:
  - h_cnt runs 0..H_total-1 (900) every clk.
  - v_cnt runs 0..V_total-1 (449) and increments when h_cnt wraps.
  - Both wrap to 0.
- Cell tracking (no multiplier, no divide-by-9):
  - x_sub counts 0..8 and col counts 0..79 during active h.
  - y_sub counts 0..15 per text row; row_base adds COLS at each y_sub wrap.
  - All of these clear at h/v wrap.
- pos register (stage 1):
  - row_base + col when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Otherwise 2047, which the framebuffer renders as space.
  - Range in active region is 0..1999.
- Stage 2: char is valid from the framebuffer.
- Stage 3: font_addr <= {char, y_sub delayed 2}.
- Stage 3+FONT_LAT: font_bits valid.
- Stage 4+FONT_LAT: pixel register.
  - pixel = font_bits[7-x_sub_d] for x_sub_d 0..7.
  - pixel = 0 for x_sub_d == 8 (inter-glyph gap).
  - pixel = 0 when de is low.
- Alignment:
  - de, hsync, vsync, frame_start and x_sub are delayed through a shift pipeline of depth L = 4+FONT_LAT.
  - All outputs are therefore mutually aligned; L = 5 at default.
- Sync timing:
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync high for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Key snapshot:
  - key0..key3 <= key_in0..key_in3 on the clk where h_cnt==0 and v_cnt==V_ACTIVE (first blank line).
  - Held at all other times.
  - A simultaneous change of key_in on that same clk is captured.
- Reset:
  - All counters 0; pos 2047; font_addr 0; key0..key3 0.
  - pixel 0, de 0, hsync 1, vsync 0, frame_start 0; the whole delay pipeline is flushed to these idle values.
  - Reset mid-frame restarts at h=0, v=0 on the next clk.
  - Outputs stay idle for L clocks after rst deasserts.
  - First frame_start appears at clock L after rst deassertion.
- frame_start: generated when h_cnt==0 and v_cnt==0, then delayed by L.

Optional Feature:
- Macro: TEXT_SCAN_CURSOR_EN.
- With it defined:
  - Extra input cur_pos[10:0] and 6-bit frame counter, incremented per frame_start.
  - A cell whose pos equals cur_pos has pixel inverted on y_sub 14 and 15 when frame counter bit 5 is 1 (blink about 1.1 Hz).
  - The gap column is included in the inversion.
  - The inversion is gated by de, and the cursor-match flag is pipelined alongside pos.
- Without it: no cur_pos port, no frame counter, and pixel is as specified above.

Test Plan:
1. Release rst, run 2 frames:
   - hsync low 108 clks every 900.
   - vsync high exactly 1800 clks every 404100.
   - de high 720 clks per line on 400 lines.
2. Capture pos at line 0:
   - 0 for 9 clks, then 1..79 in steps of 9 clks.
   - 2047 during h blank.
   - Line 16 starts at 80; line 399 ends at 1999.
3. Model framebuffer returning 0x41 for pos 0 and a ROM returning 0xA5:
   - font_addr=0x410 at line 0.
   - First 9 pixels = 1,0,1,0,0,1,0,1,0 starting with frame_start.
4. Set key_in0=0x3C mid-active at line 100:
   - key0 keeps its old value until h=0, v=400, then becomes 0x3C.
   - Change key_in0 again at line 420 → no update until the next frame.
5. Assert rst for 1 clk at h=500, v=200:
   - Next clk: pos=2047, de=0, hsync=1, key0..key3=0.
   - frame_start appears 5 clks after rst deasserts.
6. TEXT_SCAN_CURSOR_EN with cur_pos=81, frame counter bit 5=1:
   - Lines 30,31, cell 81 pixel = inverted glyph including the gap.
   - Line 29 unchanged; no inversion when bit 5=0.
